// File: rtl/dcache_controller.sv
// Direct-mapped, write-back / write-allocate data cache controller for an in-order pipeline.
// Hits are combinational. Misses run IDLE -> [WRITEBACK] -> REFILL -> FILLED against a line-wide memory port.
module dcache_controller #(
    parameter int NUM_LINES = 32,
    parameter int LINE_BITS = 256,
    parameter int TAG_BITS  = 22
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_we_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    localparam int IDX_BITS = $clog2(NUM_LINES);
    localparam int OFF_BITS = $clog2(LINE_BITS / 32);
    localparam int LOW_BITS = OFF_BITS + 2;
    localparam logic [LOW_BITS-1:0] LOW_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        FILLED    = 2'd3
    } state_t;

    state_t                state_r;
    logic [NUM_LINES-1:0]  valid_r;
    logic [NUM_LINES-1:0]  dirty_r;
    logic [TAG_BITS-1:0]   tag_r  [NUM_LINES];
    logic [LINE_BITS-1:0]  data_r [NUM_LINES];
    logic [TAG_BITS-1:0]   miss_tag_r;
    logic [IDX_BITS-1:0]   miss_idx_r;

    logic [TAG_BITS-1:0]   req_tag_s;
    logic [IDX_BITS-1:0]   req_idx_s;
    logic [OFF_BITS-1:0]   req_off_s;
    logic                  lookup_s;
    logic                  hit_s;
    logic                  store_hit_s;
    logic                  victim_dirty_s;
    logic                  refill_done_s;
    logic [31:0]           hit_word_s;
    logic [LINE_BITS-1:0]  merged_line_s;
    logic                  unused_addr_s;

    assign req_tag_s      = cpu_addr_i[31 -: TAG_BITS];
    assign req_idx_s      = cpu_addr_i[LOW_BITS +: IDX_BITS];
    assign req_off_s      = cpu_addr_i[2 +: OFF_BITS];
    assign unused_addr_s  = ^cpu_addr_i[1:0];

    // Tag lookup is only meaningful while no line transfer is in flight.
    assign lookup_s       = (state_r == IDLE) || (state_r == FILLED);
    assign hit_s          = cpu_req_i & lookup_s & valid_r[req_idx_s] & (tag_r[req_idx_s] == req_tag_s);
    assign store_hit_s    = hit_s & cpu_we_i;
    assign victim_dirty_s = valid_r[req_idx_s] & dirty_r[req_idx_s];
    assign refill_done_s  = (state_r == REFILL) & mem_ack_i;
    assign hit_word_s     = data_r[req_idx_s][{req_off_s, 5'b00000} +: 32];

    assign cpu_stall_o    = (state_r == WRITEBACK) | (state_r == REFILL) | (cpu_req_i & ~hit_s);
    assign cpu_data_o     = (hit_s & ~cpu_we_i) ? hit_word_s : 32'h0000_0000;

    // Indexed line with the store word replaced, used for store hits.
    always_comb begin
        merged_line_s = data_r[req_idx_s];
        merged_line_s[{req_off_s, 5'b00000} +: 32] = cpu_data_i;
    end

    // Tag and data arrays; a refill and a store hit can never fall in the same cycle.
    always_ff @(posedge clk_i) begin
        if (refill_done_s) begin
            data_r[miss_idx_r] <= mem_data_i;
            tag_r[miss_idx_r]  <= miss_tag_r;
        end else if (store_hit_s) begin
            data_r[req_idx_s]  <= merged_line_s;
        end
    end

    // Miss FSM, valid/dirty bits and the registered memory request.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= IDLE;
            valid_r      <= '0;
            dirty_r      <= '0;
            miss_tag_r   <= '0;
            miss_idx_r   <= '0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= 32'h0000_0000;
            mem_data_o   <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cpu_req_i && !hit_s) begin
                        miss_tag_r   <= req_tag_s;
                        miss_idx_r   <= req_idx_s;
                        mem_enable_o <= 1'b1;
                        if (victim_dirty_s) begin
                            state_r     <= WRITEBACK;
                            mem_write_o <= 1'b1;
                            mem_addr_o  <= {tag_r[req_idx_s], req_idx_s, LOW_ZERO};
                            mem_data_o  <= data_r[req_idx_s];
                        end else begin
                            state_r     <= REFILL;
                            mem_write_o <= 1'b0;
                            mem_addr_o  <= {req_tag_s, req_idx_s, LOW_ZERO};
                        end
                    end else if (store_hit_s) begin
                        dirty_r[req_idx_s] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (mem_ack_i) begin
                        state_r     <= REFILL;
                        mem_write_o <= 1'b0;
                        mem_addr_o  <= {miss_tag_r, miss_idx_r, LOW_ZERO};
                    end
                end
                REFILL: begin
                    if (mem_ack_i) begin
                        state_r             <= FILLED;
                        mem_enable_o        <= 1'b0;
                        valid_r[miss_idx_r] <= 1'b1;
                        dirty_r[miss_idx_r] <= 1'b0;
                    end
                end
                FILLED: begin
                    state_r <= IDLE;
                    if (store_hit_s) begin
                        dirty_r[req_idx_s] <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_controller.sv
// Randomized scoreboard bench for dcache_controller: a line-level cache/memory model predicts CPU
// responses and memory transactions; monitors pop and compare whenever the DUT presents them.
module tb_dcache_controller;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i, cpu_we_i;
    logic [31:0]  cpu_addr_i, cpu_data_i, cpu_data_o;
    logic         cpu_stall_o, mem_enable_o, mem_write_o, mem_ack_i;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o, mem_data_i;

    dcache_controller dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { logic wr; logic [31:0] addr; logic [255:0] data; int lat; } mem_exp_t;
    typedef struct { logic [31:0] data; int stalls; } cpu_exp_t;

    mem_exp_t mem_q[$];
    cpu_exp_t cpu_q[$];
    int checks = 0;
    int errors = 0;

    // Reference cache: per-line valid/dirty/tag and eight words; two word-addressed memories.
    logic        r_valid [32];
    logic        r_dirty [32];
    logic [21:0] r_tag   [32];
    logic [31:0] r_word  [32][8];
    logic [31:0] ref_mem [int];
    logic [31:0] env_mem [int];
    int          force_lat = 0;
    logic [31:0] last_mem_addr = 32'h0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk(name, {224'd0, act}, {224'd0, exp});
    endtask

    task automatic fail_now(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: got %s", name, what);
    endtask

    function automatic logic [31:0] init_word(input int wa);
        return (32'(wa) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input int wa);
        return ref_mem.exists(wa) ? ref_mem[wa] : init_word(wa);
    endfunction

    function automatic logic [31:0] env_rd(input int wa);
        return env_mem.exists(wa) ? env_mem[wa] : init_word(wa);
    endfunction

    function automatic int pick_lat();
        return (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
    endfunction

    // Predict one access: memory transactions it causes, stall cycles, and the data returned.
    task automatic model_access(input logic [31:0] addr, input logic we, input logic [31:0] data,
                                output logic [31:0] exp_data, output int stalls);
        logic [4:0]  idx;
        logic [2:0]  off;
        logic [21:0] tag;
        logic [31:0] la;
        mem_exp_t    e;
        idx = addr[9:5];
        off = addr[4:2];
        tag = addr[31:10];
        stalls = 0;
        if (!(r_valid[idx] && r_tag[idx] == tag)) begin
            stalls = 1;
            if (r_valid[idx] && r_dirty[idx]) begin
                la = {r_tag[idx], idx, 5'b00000};
                e.wr = 1'b1;
                e.addr = la;
                for (int w = 0; w < 8; w++) begin
                    e.data[w*32 +: 32] = r_word[idx][w];
                    ref_mem[int'(la >> 2) + w] = r_word[idx][w];
                end
                e.lat = pick_lat();
                stalls += e.lat;
                mem_q.push_back(e);
            end
            la = {tag, idx, 5'b00000};
            e.wr = 1'b0;
            e.addr = la;
            e.data = '0;
            e.lat = pick_lat();
            stalls += e.lat;
            mem_q.push_back(e);
            last_mem_addr = la;
            for (int w = 0; w < 8; w++) r_word[idx][w] = ref_rd(int'(la >> 2) + w);
            r_valid[idx] = 1'b1;
            r_dirty[idx] = 1'b0;
            r_tag[idx]   = tag;
        end
        if (we) begin
            r_word[idx][off] = data;
            r_dirty[idx] = 1'b1;
            exp_data = 32'h0;
        end else begin
            exp_data = r_word[idx][off];
        end
    endtask

    // Memory responder and memory-side monitor.
    logic     busy = 1'b0, ack_up = 1'b0, spur = 1'b0, abandon = 1'b0;
    logic     cur_wr;
    logic [31:0] cur_addr;
    int       cnt;
    mem_exp_t resp_e;

    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (ack_up) begin
                mem_ack_i = 1'b0;
                ack_up = 1'b0;
                busy = 1'b0;
                abandon = 1'b0;
            end
            if (!busy && spur) begin
                mem_ack_i  = 1'b1;
                mem_data_i = {8{$urandom()}};
                ack_up = 1'b1;
                spur = 1'b0;
            end else if (!busy && mem_enable_o) begin
                busy = 1'b1;
                cur_wr = mem_write_o;
                cur_addr = mem_addr_o;
                if (mem_q.size() == 0) begin
                    fail_now("mem_request", $sformatf("unexpected request at %0h, expected none", mem_addr_o));
                    cnt = 1;
                end else begin
                    resp_e = mem_q.pop_front();
                    chk32("mem_write", 32'(mem_write_o), 32'(resp_e.wr));
                    chk32("mem_addr", mem_addr_o, resp_e.addr);
                    if (resp_e.wr) chk("wb_data", mem_data_o, resp_e.data);
                    cnt = resp_e.lat;
                end
            end
            if (busy && !ack_up) begin
                cnt--;
                if (cnt <= 0) begin
                    if (!abandon) begin
                        chk32("mem_hold_addr", mem_addr_o, cur_addr);
                        chk32("mem_hold_en", 32'(mem_enable_o), 32'd1);
                    end
                    if (cur_wr) begin
                        for (int w = 0; w < 8; w++) env_mem[int'(cur_addr >> 2) + w] = mem_data_o[w*32 +: 32];
                    end else begin
                        for (int w = 0; w < 8; w++) mem_data_i[w*32 +: 32] = env_rd(int'(cur_addr >> 2) + w);
                    end
                    mem_ack_i = 1'b1;
                    ack_up = 1'b1;
                end
            end
        end
    end

    // CPU-side monitor: counts stall cycles and scores each completed access.
    int       stall_cnt = 0;
    cpu_exp_t ce_mon;

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i && cpu_req_i) begin
                if (cpu_stall_o) begin
                    stall_cnt++;
                end else begin
                    if (cpu_q.size() == 0) begin
                        fail_now("cpu_complete", "access completed with nothing expected");
                    end else begin
                        ce_mon = cpu_q.pop_front();
                        chk32("cpu_data", cpu_data_o, ce_mon.data);
                        chk32("stall_cycles", 32'(stall_cnt), 32'(ce_mon.stalls));
                    end
                    stall_cnt = 0;
                end
            end else begin
                stall_cnt = 0;
            end
        end
    end

    task automatic wait_not_stalled();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_i);
            if (!cpu_stall_o) done = 1'b1;
        end
        if (!done) fail_now("stall_timeout", "stall still high after 300 cycles, expected release");
    endtask

    task automatic wait_refill();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_i);
            if (mem_enable_o && !mem_write_o) done = 1'b1;
        end
        if (!done) fail_now("refill_timeout", "no refill request within 300 cycles");
    endtask

    task automatic wait_mem_idle();
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk_i);
            if (!mem_enable_o && !busy) done = 1'b1;
        end
        if (!done) fail_now("idle_timeout", "memory port still busy after 300 cycles");
    endtask

    // All driver tasks start and end one time unit after a rising edge.
    task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] data);
        cpu_exp_t ce;
        logic [31:0] ed;
        int st;
        model_access(addr, we, data, ed, st);
        ce.data = ed;
        ce.stalls = st;
        cpu_q.push_back(ce);
        cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_data_i = data;
        wait_not_stalled();
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
    endtask

    task automatic issue_drop(input logic [31:0] addr);
        logic [31:0] ed;
        int st;
        force_lat = 4;
        model_access(addr, 1'b0, 32'h0, ed, st);
        force_lat = 0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = addr;
        wait_refill();
        @(posedge clk_i); #1;
        cpu_req_i = 1'b0;
        wait_mem_idle();
        @(posedge clk_i); #1;
    endtask

    task automatic issue_reset(input logic [31:0] addr);
        logic [31:0] ed;
        int st;
        force_lat = 8;
        model_access(addr, 1'b0, 32'h0, ed, st);
        force_lat = 0;
        cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = addr;
        wait_refill();
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b0; cpu_req_i = 1'b0; abandon = 1'b1;
        @(negedge clk_i);
        chk32("midrst_en", 32'(mem_enable_o), 32'd0);
        chk32("midrst_addr", mem_addr_o, 32'h0);
        chk32("midrst_stall", 32'(cpu_stall_o), 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        for (int i = 0; i < 32; i++) begin r_valid[i] = 1'b0; r_dirty[i] = 1'b0; end
        wait_mem_idle();
        @(negedge clk_i);
        chk32("late_ack_en", 32'(mem_enable_o), 32'd0);
        chk32("late_ack_addr", mem_addr_o, 32'h0);
        @(posedge clk_i); #1;
    endtask

    task automatic spurious_ack();
        spur = 1'b1;
        for (int i = 0; i < 20 && spur; i++) @(negedge clk_i);
        @(negedge clk_i);
        chk32("spur_en", 32'(mem_enable_o), 32'd0);
        chk32("spur_addr", mem_addr_o, last_mem_addr);
        chk32("spur_stall", 32'(cpu_stall_o), 32'd0);
        @(posedge clk_i); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        rst_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'h0; cpu_data_i = 32'h0;
        for (int i = 0; i < 32; i++) begin r_valid[i] = 1'b0; r_dirty[i] = 1'b0; end
        ref_mem[32'h404 >> 2] = 32'hDEAD_BEEF;
        env_mem[32'h404 >> 2] = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk_i);
        chk32("rst_mem_en", 32'(mem_enable_o), 32'd0);
        chk32("rst_mem_we", 32'(mem_write_o), 32'd0);
        chk32("rst_mem_addr", mem_addr_o, 32'h0);
        chk("rst_mem_data", mem_data_o, 256'd0);
        chk32("rst_stall", 32'(cpu_stall_o), 32'd0);
        chk32("rst_cpu_data", cpu_data_o, 32'h0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        force_lat = 10;
        issue(32'h0000_0404, 1'b0, 32'h0);
        force_lat = 0;
        issue(32'h0000_0408, 1'b1, 32'h1234_5678);
        issue(32'h0000_0408, 1'b0, 32'h0);
        issue(32'h0000_1400, 1'b0, 32'h0);
        issue_reset(32'h0000_2040);
        issue(32'h0000_0404, 1'b0, 32'h0);
        issue_drop(32'h0000_0060);
        issue(32'h0000_0060, 1'b0, 32'h0);
        spurious_ack();
        issue(32'h0000_0064, 1'b0, 32'h0);

        for (int n = 0; n < 250; n++) begin
            a = {20'd0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
            issue(a, 1'($urandom_range(0, 1)), $urandom());
        end

        repeat (5) @(posedge clk_i);
        chk32("cpu_q_drained", 32'(cpu_q.size()), 32'd0);
        chk32("mem_q_drained", 32'(mem_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
